eth_rx_frame_parser: RTL

Successor to the fixed-offset octet counter in the RMII receive path. Consumes the byte stream from the RMII receiver, extracts the Ethernet header (destination MAC, source MAC, optional 802.1Q tag, EtherType) and applies destination-MAC filtering. Packs the payload into OUT_W-bit words with byte-keep and a last-word flag, and reports frame status and payload length at end of frame. Sits between the receiver and the RX clock-domain-crossing FIFO, all on the 50 MHz RMII clock.

---
 rtl/eth_rx_frame_parser.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_parser.sv
// Ethernet receive frame parser: header extraction, destination-MAC filter,
// payload packing into OUT_W-bit words and end-of-frame status on the RMII clock.
module eth_rx_frame_parser #(
  parameter int          OUT_W         = 32,
  parameter bit          VLAN_EN       = 1'b1,
  parameter bit          MAC_FILTER_EN = 1'b1,
  parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_01,
  parameter int          MAX_PAYLOAD   = 1500
) (
  input  logic               clk_50_mhz,
  input  logic               rst_n,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  input  logic               frame_end_i,
  input  logic               frame_err_i,
  output logic               hdr_valid_o,
  output logic [47:0]        dst_mac_o,
  output logic [47:0]        src_mac_o,
  output logic [15:0]        eth_type_o,
  output logic               vlan_present_o,
  output logic [15:0]        vlan_tci_o,
  output logic [OUT_W-1:0]   word_o,
  output logic               word_valid_o,
  output logic [OUT_W/8-1:0] word_keep_o,
  output logic               word_last_o,
  output logic               frame_done_o,
  output logic               frame_ok_o,
  output logic [15:0]        payload_len_o,
  output logic [15:0]        drop_cnt_o
);
  localparam int NB  = OUT_W / 8;
  localparam int FCW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TAG, S_PAY, S_DROP, S_FLUSH, S_LASTW, S_DONE
  } state_t;

  state_t           r_state;
  logic [135:0]     r_sh;
  logic [15:0]      r_idx;
  logic [15:0]      r_len;
  logic [OUT_W-1:0] r_fill;
  logic [OUT_W-1:0] r_hold;
  logic [FCW-1:0]   r_fcnt;
  logic             r_hold_v;
  logic             r_err;
  logic             r_trunc;

  logic [143:0]     w_sh;
  logic             w_err, w_trunc, w_take, w_full, w_flush, w_reject;
  logic             w_tag_start, w_hdr_last;
  logic [OUT_W-1:0] w_fill_add, w_fill, w_hold;
  logic [FCW-1:0]   w_fcnt;
  logic             w_hold_v;
  logic [15:0]      w_len;

  function automatic logic [NB-1:0] keep_of(input logic [FCW-1:0] n);
    keep_of = ~({NB{1'b1}} >> n);
  endfunction

  // Header bytes shift in so the newest byte is always at [7:0].
  assign w_sh        = {r_sh, byte_i};
  assign w_err       = r_err | (frame_err_i && (r_state inside {S_HDR, S_TAG, S_PAY}));
  assign w_take      = (r_state == S_PAY) && byte_valid_i && (r_len < 16'(MAX_PAYLOAD));
  assign w_trunc     = r_trunc | ((r_state == S_PAY) && byte_valid_i && !w_take);
  assign w_full      = w_take && (r_fcnt == FCW'(NB - 1));
  assign w_fill_add  = r_fill | (OUT_W'(byte_i) << (8 * (NB - 1 - int'(r_fcnt))));
  assign w_reject    = MAC_FILTER_EN && (w_sh[47:0] != LOCAL_MAC) && (w_sh[47:0] != 48'hFFFF_FFFF_FFFF);
  assign w_tag_start = (r_state == S_HDR) && (r_idx == 16'd13) && VLAN_EN && (w_sh[15:0] == 16'h8100);
  assign w_hdr_last  = ((r_state == S_HDR) && (r_idx == 16'd13) && !w_tag_start) ||
                       ((r_state == S_TAG) && (r_idx == 16'd17));
  assign w_len       = r_len + {15'd0, w_take};

  // Packing state after this cycle's byte, before any end-of-frame flush.
  always_comb begin
    w_fill   = r_fill;
    w_fcnt   = r_fcnt;
    w_hold   = r_hold;
    w_hold_v = r_hold_v;
    if (w_full) begin
      w_fill   = '0;
      w_fcnt   = '0;
      w_hold   = w_fill_add;
      w_hold_v = 1'b1;
    end else if (w_take) begin
      w_fill = w_fill_add;
      w_fcnt = r_fcnt + FCW'(1);
    end
  end

  // A byte that fills a word while one is already held emits the held word now,
  // so the flush must wait a cycle for the new hold to drain.
  assign w_flush = (r_state == S_FLUSH) ||
                   ((r_state == S_PAY) && frame_end_i && !(w_full && r_hold_v));

  always_ff @(posedge clk_50_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_sh           <= '0;
      r_idx          <= '0;
      r_len          <= '0;
      r_fill         <= '0;
      r_hold         <= '0;
      r_fcnt         <= '0;
      r_hold_v       <= 1'b0;
      r_err          <= 1'b0;
      r_trunc        <= 1'b0;
      hdr_valid_o    <= 1'b0;
      dst_mac_o      <= '0;
      src_mac_o      <= '0;
      eth_type_o     <= '0;
      vlan_present_o <= 1'b0;
      vlan_tci_o     <= '0;
      word_o         <= '0;
      word_valid_o   <= 1'b0;
      word_keep_o    <= '0;
      word_last_o    <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_ok_o     <= 1'b0;
      payload_len_o  <= '0;
      drop_cnt_o     <= '0;
    end else begin
      hdr_valid_o  <= 1'b0;
      word_valid_o <= 1'b0;
      word_last_o  <= 1'b0;
      frame_done_o <= 1'b0;
      r_err        <= w_err;
      r_trunc      <= w_trunc;
      r_fill       <= w_fill;
      r_fcnt       <= w_fcnt;
      r_hold       <= w_hold;
      r_hold_v     <= w_hold_v;
      r_len        <= w_len;
      if (byte_valid_i && (r_state inside {S_HDR, S_TAG, S_PAY}) && (r_idx != 16'hFFFF))
        r_idx <= r_idx + 16'd1;
      if (w_full && r_hold_v) begin
        word_o       <= r_hold;
        word_keep_o  <= '1;
        word_valid_o <= 1'b1;
      end

      case (r_state)
        S_IDLE: if (byte_valid_i) begin
          r_sh    <= w_sh[135:0];
          r_idx   <= 16'd1;
          r_err   <= 1'b0;
          r_trunc <= 1'b0;
          r_len   <= '0;
          if (frame_end_i) begin
            frame_done_o  <= 1'b1;
            frame_ok_o    <= 1'b0;
            payload_len_o <= '0;
            r_state       <= S_DONE;
          end else begin
            r_state <= S_HDR;
          end
        end
        S_HDR, S_TAG: begin
          if (byte_valid_i) r_sh <= w_sh[135:0];
          if (byte_valid_i && (r_state == S_HDR) && (r_idx == 16'd5) && w_reject) begin
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            r_state <= frame_end_i ? S_IDLE : S_DROP;
          end else if (byte_valid_i && w_hdr_last) begin
            hdr_valid_o    <= 1'b1;
            dst_mac_o      <= (r_state == S_TAG) ? w_sh[143:96] : w_sh[111:64];
            src_mac_o      <= (r_state == S_TAG) ? w_sh[95:48] : w_sh[63:16];
            eth_type_o     <= w_sh[15:0];
            vlan_present_o <= (r_state == S_TAG);
            vlan_tci_o     <= (r_state == S_TAG) ? w_sh[31:16] : 16'h0000;
            if (frame_end_i) begin
              frame_done_o  <= 1'b1;
              frame_ok_o    <= !w_err;
              payload_len_o <= '0;
              r_state       <= S_DONE;
            end else begin
              r_state <= S_PAY;
            end
          end else if (frame_end_i) begin
            frame_done_o  <= 1'b1;
            frame_ok_o    <= 1'b0;
            payload_len_o <= '0;
            r_state       <= S_DONE;
          end else if (byte_valid_i && w_tag_start) begin
            r_state <= S_TAG;
          end
        end
        S_PAY:   if (frame_end_i && w_full && r_hold_v) r_state <= S_FLUSH;
        S_DROP:  if (frame_end_i) r_state <= S_IDLE;
        S_FLUSH: ;
        S_LASTW: begin
          frame_done_o  <= 1'b1;
          frame_ok_o    <= !r_err && !r_trunc;
          payload_len_o <= r_len;
          r_state       <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Held word leaves first; a partial fill word follows it as the last word.
      if (w_flush) begin
        if (w_hold_v) begin
          word_o       <= w_hold;
          word_keep_o  <= '1;
          word_valid_o <= 1'b1;
          word_last_o  <= (w_fcnt == '0);
          r_hold_v     <= 1'b0;
          r_state      <= (w_fcnt == '0) ? S_LASTW : S_FLUSH;
        end else if (w_fcnt != '0) begin
          word_o       <= w_fill;
          word_keep_o  <= keep_of(w_fcnt);
          word_valid_o <= 1'b1;
          word_last_o  <= 1'b1;
          r_fill       <= '0;
          r_fcnt       <= '0;
          r_state      <= S_LASTW;
        end else begin
          frame_done_o  <= 1'b1;
          frame_ok_o    <= !w_err && !w_trunc;
          payload_len_o <= w_len;
          r_state       <= S_DONE;
        end
      end
    end
  end

endmodule
